// File: rtl/axis_byte_deser_pkg.sv
// Shared UART timing package.
// Holds the UART receiver sample constants and the helpers that turn the
// clock frequency and bit rate into byte-time and inter-byte timeout
// lengths, expressed in clock cycles. It also holds the saturating
// increment used by the drop counter.
package axis_byte_deser_pkg;

    // Receiver oversampling and the mid-bit sample point used by uart_rx.
    localparam int UART_OVERSAMPLE  = 16;
    localparam int UART_SAMPLE_MID  = UART_OVERSAMPLE / 2;

    // Each UART frame carries one start bit and one stop bit around the data.
    localparam int UART_FRAME_EXTRA = 2;

    // Clock cycles taken by one UART frame of data_width data bits.
    function automatic real byte_time_clks(real clk_freq, int baud_rate, int data_width);
        return clk_freq / real'(baud_rate) * real'(data_width + UART_FRAME_EXTRA);
    endfunction

    // Inter-byte gap, rounded to the nearest whole clock cycle.
    function automatic int timeout_clks(real clk_freq, int baud_rate,
                                        int data_width, int timeout_bytes);
        return $rtoi(byte_time_clks(clk_freq, baud_rate, data_width)
                     * real'(timeout_bytes) + 0.5);
    endfunction

    // 8-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(logic [7:0] value);
        if (value == 8'hFF) begin
            return 8'hFF;
        end else begin
            return value + 8'd1;
        end
    endfunction

endpackage

// File: rtl/axis_byte_deser_idle_timer.sv
// Inter-byte idle timer.
// Counts clock cycles while enabled. expire_o is high for the single cycle
// in which the count sits at LIMIT-1 and the timer is neither cleared nor
// disabled. clear_i has priority over enable_i.
// Ports:
//   clk      - clock
//   arstn    - asynchronous active-low reset
//   clear_i  - return the count to zero
//   enable_i - advance the count
//   expire_o - limit reached this cycle
module idle_timer #(
    parameter int LIMIT = 2
) (
    input  logic clk,
    input  logic arstn,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int            CW   = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count and expiry decode.
    always_comb begin
        count_d  = count_q;
        expire_o = 1'b0;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            if (count_q == LAST) begin
                // Hold at the limit; the owner clears the timer after expiry.
                expire_o = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/axis_byte_deser.sv
// AXI-Stream byte-to-word deserialiser for a UART receive path.
// Packs PKT_BYTES bytes big-endian into one output word. A partial word is
// abandoned on an upstream error or when the inter-byte gap exceeds
// TIMEOUT_BYTES byte-times; each abandon bumps a saturating drop counter.
// Ports:
//   clk, arstn          - clock and asynchronous active-low reset
//   s_axis_*            - byte input stream
//   err_in              - upstream frame/overrun error level
//   m_axis_*            - word output stream, registered
//   timeout_error       - one-cycle pulse when a partial word times out
//   drop_count          - saturating count of abandoned partial words
//   busy                - a partial word is being assembled
module axis_byte_deser
    import axis_byte_deser_pkg::*;
#(
    parameter real CLK_FREQ      = 100_000_000.0,
    parameter int  BAUD_RATE     = 115_200,
    parameter int  DATA_WIDTH    = 8,
    parameter int  PKT_BYTES     = 4,
    parameter int  TIMEOUT_BYTES = 4
) (
    input  logic                            clk,
    input  logic                            arstn,
    input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            err_in,
    output logic [DATA_WIDTH*PKT_BYTES-1:0] m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            timeout_error,
    output logic [7:0]                      drop_count,
    output logic                            busy
);

    localparam int            WW           = DATA_WIDTH * PKT_BYTES;
    // The last byte of a word goes straight to the output register, so the
    // shift register only needs to hold the first PKT_BYTES-1 bytes.
    localparam int            SW           = DATA_WIDTH * (PKT_BYTES - 1);
    localparam int            CW           = $clog2(PKT_BYTES + 1);
    localparam logic [CW-1:0] LAST_IDX     = CW'(PKT_BYTES - 1);
    localparam int            TIMEOUT_CLKS = timeout_clks(CLK_FREQ, BAUD_RATE,
                                                          DATA_WIDTH, TIMEOUT_BYTES);

    logic [CW-1:0] byte_count_q, byte_count_d;
    logic [SW-1:0] shift_q,      shift_d;
    logic [WW-1:0] out_data_q,   out_data_d;
    logic          out_valid_q,  out_valid_d;
    logic          timeout_q,    timeout_d;
    logic [7:0]    drop_q,       drop_d;

    logic accept_s;
    logic expire_s;
    logic timer_clear_s;
    logic timer_en_s;

    // Stall only when the final byte would need an output register that is
    // still occupied and not being drained this cycle.
    assign s_axis_tready = !((byte_count_q == LAST_IDX) && out_valid_q && !m_axis_tready);
    assign accept_s      = s_axis_tvalid && s_axis_tready;

    // An error also clears the timer so it can never expire alongside an
    // error discard and raise a spurious timeout pulse.
    assign timer_clear_s = accept_s || (byte_count_q == '0) || err_in;
    assign timer_en_s    = (byte_count_q != '0);

    idle_timer #(
        .LIMIT    (TIMEOUT_CLKS)
    ) u_idle_timer (
        .clk      (clk),
        .arstn    (arstn),
        .clear_i  (timer_clear_s),
        .enable_i (timer_en_s),
        .expire_o (expire_s)
    );

    // Word assembly, discard handling and output register next state.
    always_comb begin
        logic load_s;
        logic drop_s;
        byte_count_d = byte_count_q;
        shift_d      = shift_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        timeout_d    = 1'b0;
        drop_d       = drop_q;
        load_s       = 1'b0;
        drop_s       = 1'b0;

        if (err_in) begin
            // Any byte accepted alongside the error is discarded too.
            byte_count_d = '0;
            shift_d      = '0;
            if (byte_count_q != '0) begin
                drop_s = 1'b1;
            end else begin
                drop_s = 1'b0;
            end
        end else if (accept_s) begin
            // A byte on the expiry cycle wins: the timer is cleared by it.
            if (byte_count_q == LAST_IDX) begin
                byte_count_d = '0;
                shift_d      = '0;
                load_s       = 1'b1;
            end else begin
                byte_count_d = byte_count_q + 1'b1;
                shift_d      = SW'({shift_q, s_axis_tdata});
            end
        end else if (expire_s) begin
            byte_count_d = '0;
            shift_d      = '0;
            timeout_d    = 1'b1;
            drop_s       = 1'b1;
        end else begin
            byte_count_d = byte_count_q;
        end

        if (load_s) begin
            out_data_d  = {shift_q, s_axis_tdata};
            out_valid_d = 1'b1;
        end else if (out_valid_q && m_axis_tready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (drop_s) begin
            drop_d = sat_inc8(drop_q);
        end else begin
            drop_d = drop_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            byte_count_q <= '0;
            shift_q      <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            timeout_q    <= 1'b0;
            drop_q       <= 8'd0;
        end else begin
            byte_count_q <= byte_count_d;
            shift_q      <= shift_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            timeout_q    <= timeout_d;
            drop_q       <= drop_d;
        end
    end

    assign m_axis_tdata  = out_data_q;
    assign m_axis_tvalid = out_valid_q;
    assign timeout_error = timeout_q;
    assign drop_count    = drop_q;
    assign busy          = (byte_count_q != '0);

endmodule

// File: doc/axis_byte_deser.md
AXIS_BYTE_DESER -- requirements
Module: axis_byte_deser

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- CLK_FREQ, 100_000_000.0 (real), clock frequency in Hz.
- BAUD_RATE, 115_200, UART bit rate of the upstream receiver.
- DATA_WIDTH, 8, input byte width.
- PKT_BYTES, 4, number of bytes per output word, at least 2.
- TIMEOUT_BYTES, 4, inter-byte gap in byte-times that abandons a partial word.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock.
- arstn, in, 1, reset, asynchronous, active-low.
- s_axis_tdata, in, DATA_WIDTH, byte from uart receiver.
- s_axis_tvalid, in, 1, byte valid.
- s_axis_tready, out, 1, byte accepted.
- err_in, in, 1, upstream frame/overrun error (level).
- m_axis_tdata, out, DATA_WIDTH*PKT_BYTES, assembled word.
- m_axis_tvalid, out, 1, word valid.
- m_axis_tready, in, 1, consumer ready.
- timeout_error, out, 1, one-cycle pulse when a partial word is dropped by timeout.
- drop_count, out, 8, saturating count of dropped partial words.
- busy, out, 1, high while byte_count != 0.

Function
REQ-003 A byte SHALL be accepted when s_axis_tvalid && s_axis_tready are both high at a rising clk edge.
REQ-004 Accepted bytes SHALL be packed big-endian: the first byte of a word lands in m_axis_tdata[MSB -: DATA_WIDTH], and the last byte in bits [DATA_WIDTH-1:0].
REQ-005 byte_count SHALL have width $clog2(PKT_BYTES+1), count 0..PKT_BYTES-1, and wrap to 0 on the accepted byte that completes a word.
REQ-006 When a word completes, it SHALL be loaded into the output register and m_axis_tvalid SHALL go high on the next cycle, giving 1 cycle of latency from the last byte accepted.
REQ-007 m_axis_tvalid SHALL stay high with m_axis_tdata stable until m_axis_tready is high, and SHALL clear after that transfer unless a new word loads in the same cycle.
REQ-008 s_axis_tready SHALL be low only when byte_count == PKT_BYTES-1 && m_axis_tvalid && !m_axis_tready; it SHALL be high otherwise. A new word may therefore load in the same cycle the old one transfers.
REQ-009 The shift register SHALL keep assembling the next word while the output register holds an untaken word.
REQ-010 TIMEOUT_CLKS SHALL equal round(CLK_FREQ/BAUD_RATE*(DATA_WIDTH+2)*TIMEOUT_BYTES).
- The timer SHALL clear on every accepted byte and whenever byte_count == 0.
- It SHALL count up while byte_count != 0.
REQ-011 When the timer reaches TIMEOUT_CLKS-1 with no byte accepted that cycle:
- byte_count SHALL go to 0.
- The partial word SHALL be discarded.
- timeout_error SHALL pulse for 1 cycle.
- drop_count SHALL increment.
REQ-012 A byte accepted in the same cycle as timer expiry SHALL win: it is appended and no timeout occurs.
REQ-013 When err_in is high with byte_count != 0, the partial word SHALL be discarded, byte_count SHALL go to 0, and drop_count SHALL increment. timeout_error SHALL NOT pulse.
REQ-014 A byte accepted while err_in is high SHALL itself be discarded, and the word SHALL restart empty.
REQ-015 When err_in is high with byte_count == 0, no drop SHALL be counted.
REQ-016 drop_count SHALL saturate at 255.
REQ-017 A discard SHALL never affect a word already in the output register.

Reset
REQ-018 While arstn is low, all state SHALL be reset asynchronously:
- byte_count = 0, timer = 0, shift register = 0.
- m_axis_tdata = 0, m_axis_tvalid = 0, timeout_error = 0.
- drop_count = 0, busy = 0.
REQ-019 s_axis_tready SHALL be 1 in reset, since it is combinational from the reset state.
REQ-020 Reset mid-word or mid-transfer SHALL drop all partial and pending data with no output.

Structure
REQ-021 The TIMEOUT_CLKS derivation and the byte-time constant (CLK_FREQ/BAUD_RATE*(DATA_WIDTH+2)) SHALL live in the shared UART package, together with the uart_rx sample constants.
REQ-022 The inter-byte timer SHALL be a sub-module named idle_timer with inputs clear and enable and a one-cycle expire output. The remaining logic SHALL stay in one module.

Verification
REQ-023 Bytes 0x12, 0x34, 0x56, 0x78 back-to-back with m_axis_tready=1 -> m_axis_tdata=0x12345678, m_axis_tvalid high exactly 1 cycle after the 4th accept.
REQ-024 m_axis_tready=0 while sending 8 bytes 0x01..0x08 -> the first word is 0x01020304 and held stable. s_axis_tready drops when 0x08 is presented. Raising m_axis_tready yields 0x01020304 then 0x05060708, with no loss.
REQ-025 Bytes 0xAA, 0xBB, then a gap of TIMEOUT_CLKS cycles, then 0x01..0x04 -> timeout_error pulses once, drop_count=1, output 0x01020304.
REQ-026 The third byte arrives exactly at timer expiry (cycle TIMEOUT_CLKS-1) -> no timeout pulse; the word completes normally.
REQ-027 err_in is pulsed after 2 bytes, then 4 bytes 0x11..0x44 follow -> drop_count=1, timeout_error stays 0, output 0x11223344.
REQ-028 arstn is asserted after 3 bytes, then 4 fresh bytes follow -> no output before the fresh word, and all outputs are at their reset values during reset.
